// File: rtl/guitar_hero_pkg.sv
// +-------------------------------------------------------------------------+
// | guitar_hero_pkg : shared screen geometry, lane spans and FSM states       |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package guitar_hero_pkg;

  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] V_ACTIVE   = 10'd480;
  localparam logic [9:0] WINDOW_TOP = 10'd380;
  localparam logic [9:0] WINDOW_BOT = 10'd383;

  localparam logic [9:0] LANE0_X0 = 10'd20;
  localparam logic [9:0] LANE0_X1 = 10'd196;
  localparam logic [9:0] LANE1_X0 = 10'd233;
  localparam logic [9:0] LANE1_X1 = 10'd408;
  localparam logic [9:0] LANE2_X0 = 10'd444;
  localparam logic [9:0] LANE2_X1 = 10'd620;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // Half-open column span [X0, X1) of the given lane.
  function automatic logic lane_hit(input logic [1:0] lane, input logic [9:0] h);
    case (lane)
      2'd0:    lane_hit = (h >= LANE0_X0) && (h < LANE0_X1);
      2'd1:    lane_hit = (h >= LANE1_X0) && (h < LANE1_X1);
      2'd2:    lane_hit = (h >= LANE2_X0) && (h < LANE2_X1);
      default: lane_hit = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_lane_engine_if.sv
// +-------------------------------------------------------------------------+
// | note_lane_engine_if : scan position in, note/lane status out            |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

interface note_lane_engine_if;
  logic       start;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       note_visible;
  logic [2:0] lane_in_window;
  logic [7:0] missed_count;
  logic       running;

  modport master (
    output start, h_count, v_count,
    input  note_visible, lane_in_window, missed_count, running
  );

  modport slave (
    input  start, h_count, v_count,
    output note_visible, lane_in_window, missed_count, running
  );
endinterface

`default_nettype wire

// File: rtl/lfsr8.sv
// +-------------------------------------------------------------------------+
// | lfsr8 : 8-bit Fibonacci LFSR, taps 8,6,5,4, with seed load and step     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module lfsr8 #(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seed_i,
  input  logic             load_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] value_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       w_fb;

  assign w_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[6:0], w_fb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/note_lane_engine.sv
// +-------------------------------------------------------------------------+
// | note_lane_engine : multi-slot falling-note source, scrolls in vblank    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module note_lane_engine
  import guitar_hero_pkg::*;
#(
  parameter int unsigned SLOTS     = 8,
  parameter int unsigned NOTE_H    = 16,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned SPAWN_GAP = 30,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  note_lane_engine_if.slave  bus
);

  localparam int unsigned SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned IDXW = $clog2(SLOTS + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLOTS);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_UPDATE = UPDATE;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      spawn_cnt_q, spawn_cnt_d;
  logic [7:0]      missed_q, missed_d;
  logic [2:0]      liw_q, liw_d;
  logic [SLOTS-1:0] active_q, active_d;
  logic [1:0]      lane_q [SLOTS];
  logic [1:0]      lane_d [SLOTS];
  logic [9:0]      y_q [SLOTS];
  logic [9:0]      y_d [SLOTS];

  logic            w_tick;
  logic [SW-1:0]   w_slot;
  logic [10:0]     w_y_next;
  logic            w_free_found;
  logic [SW-1:0]   w_free_idx;
  logic [1:0]      w_lfsr;
  logic [1:0]      w_spawn_lane;
  logic            w_lfsr_load;
  logic            w_lfsr_step;
  logic [2:0]      w_window;
  logic [SLOTS-1:0] w_hit;

  lfsr8 #(
    .SEED  (LFSR_SEED),
    .OUT_W (2)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed_i  (LFSR_SEED),
    .load_i  (w_lfsr_load),
    .step_i  (w_lfsr_step),
    .value_o (w_lfsr)
  );

  assign w_tick       = (bus.h_count == 10'd0) && (bus.v_count == V_ACTIVE);
  assign w_slot       = idx_q[SW-1:0];
  assign w_y_next     = {1'b0, y_q[w_slot]} + 11'(SPEED);
  assign w_spawn_lane = (w_lfsr == 2'd3) ? 2'd0 : w_lfsr;

  // Lowest-index free slot wins; scanning downward lets the last hit stick.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    w_window = '0;
    for (int i = 0; i < SLOTS; i++) begin
      for (int l = 0; l < 3; l++) begin
        if (active_q[i] && (lane_q[i] == 2'(l)) && (y_q[i] <= WINDOW_BOT) &&
            (({1'b0, y_q[i]} + 11'(NOTE_H)) > {1'b0, WINDOW_TOP})) begin
          w_window[l] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spawn_cnt_d = spawn_cnt_q;
    missed_d    = missed_q;
    liw_d       = liw_q;
    active_d    = active_q;
    lane_d      = lane_q;
    y_d         = y_q;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          idx_d       = '0;
          spawn_cnt_d = '0;
          missed_d    = '0;
          liw_d       = '0;
          active_d    = '0;
          w_lfsr_load = 1'b1;
          for (int i = 0; i < SLOTS; i++) begin
            lane_d[i] = '0;
            y_d[i]    = '0;
          end
        end
      end
      S_RUN: begin
        if (w_tick) begin
          state_d = S_UPDATE;
          idx_d   = '0;
        end
      end
      S_UPDATE: begin
        if (idx_q != LAST_IDX) begin
          if (active_q[w_slot]) begin
            if (w_y_next >= {1'b0, V_ACTIVE}) begin
              active_d[w_slot] = 1'b0;
              if (missed_q != 8'hFF) begin
                missed_d = missed_q + 8'd1;
              end
            end else begin
              y_d[w_slot] = w_y_next[9:0];
            end
          end
          idx_d = idx_q + IDXW'(1);
        end else begin
          // Spawn cycle: slot moves are complete, so the window reflects this frame.
          w_lfsr_step = 1'b1;
          liw_d       = w_window;
          state_d     = S_RUN;
          idx_d       = '0;
          if (spawn_cnt_q != 8'd0) begin
            spawn_cnt_d = spawn_cnt_q - 8'd1;
          end else begin
            spawn_cnt_d = 8'(SPAWN_GAP - 1);
            if (w_free_found) begin
              active_d[w_free_idx] = 1'b1;
              lane_d[w_free_idx]   = w_spawn_lane;
              y_d[w_free_idx]      = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      spawn_cnt_q <= '0;
      missed_q    <= '0;
      liw_q       <= '0;
      active_q    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        lane_q[i] <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spawn_cnt_q <= spawn_cnt_d;
      missed_q    <= missed_d;
      liw_q       <= liw_d;
      active_q    <= active_d;
      lane_q      <= lane_d;
      y_q         <= y_d;
    end
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    logic [10:0] w_bot;
    assign w_bot    = {1'b0, y_q[s]} + 11'(NOTE_H);
    assign w_hit[s] = active_q[s] && (bus.v_count >= y_q[s]) &&
                      ({1'b0, bus.v_count} < w_bot) && lane_hit(lane_q[s], bus.h_count);
  end

  assign bus.note_visible   = (|w_hit) && (bus.h_count < H_ACTIVE) && (bus.v_count < V_ACTIVE);
  assign bus.lane_in_window = liw_q;
  assign bus.missed_count   = missed_q;
  assign bus.running        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_note_lane_engine.sv
// +-------------------------------------------------------------------------+
// | tb_note_lane_engine : frame-level reference model vs three DUT configs  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_note_lane_engine;

  localparam int NH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int         sel;
  logic [9:0] tb_h;
  logic [9:0] tb_v;
  logic       tb_start;
  int         vectors;
  int         miscompares;

  note_lane_engine_if if_a ();
  note_lane_engine_if if_b ();
  note_lane_engine_if if_c ();

  assign if_a.start   = (sel == 0) ? tb_start : 1'b0;
  assign if_a.h_count = (sel == 0) ? tb_h : 10'd5;
  assign if_a.v_count = (sel == 0) ? tb_v : 10'd0;
  assign if_b.start   = (sel == 1) ? tb_start : 1'b0;
  assign if_b.h_count = (sel == 1) ? tb_h : 10'd5;
  assign if_b.v_count = (sel == 1) ? tb_v : 10'd0;
  assign if_c.start   = (sel == 2) ? tb_start : 1'b0;
  assign if_c.h_count = (sel == 2) ? tb_h : 10'd5;
  assign if_c.v_count = (sel == 2) ? tb_v : 10'd0;

  logic       o_vis, o_run;
  logic [2:0] o_liw;
  logic [7:0] o_miss;
  assign o_vis  = (sel == 0) ? if_a.note_visible   : (sel == 1) ? if_b.note_visible   : if_c.note_visible;
  assign o_run  = (sel == 0) ? if_a.running        : (sel == 1) ? if_b.running        : if_c.running;
  assign o_liw  = (sel == 0) ? if_a.lane_in_window : (sel == 1) ? if_b.lane_in_window : if_c.lane_in_window;
  assign o_miss = (sel == 0) ? if_a.missed_count   : (sel == 1) ? if_b.missed_count   : if_c.missed_count;

  note_lane_engine #(.SLOTS(8), .NOTE_H(16), .SPEED(2), .SPAWN_GAP(30), .LFSR_SEED(8'hA5))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  note_lane_engine #(.SLOTS(2), .NOTE_H(16), .SPEED(1), .SPAWN_GAP(1), .LFSR_SEED(8'hA5))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
  note_lane_engine #(.SLOTS(16), .NOTE_H(16), .SPEED(15), .SPAWN_GAP(1), .LFSR_SEED(8'hA5))
    u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // Frame-level reference: a list of notes that move, exit and spawn once per frame.
  int         m_slots, m_speed, m_gap, m_cnt, m_missed, m_exits;
  bit         m_act  [16];
  int         m_y    [16];
  int         m_lane [16];
  logic [7:0] m_lfsr;
  int         lx0 [3] = '{20, 233, 444};
  int         lx1 [3] = '{196, 408, 620};

  task automatic model_start(input int slots, input int speed, input int gap);
    m_slots = slots; m_speed = speed; m_gap = gap;
    m_cnt = 0; m_missed = 0; m_exits = 0; m_lfsr = 8'hA5;
    for (int s = 0; s < 16; s++) begin m_act[s] = 0; m_y[s] = 0; m_lane[s] = 0; end
  endtask

  task automatic model_frame();
    int f;
    for (int s = 0; s < m_slots; s++) begin
      if (m_act[s]) begin
        if (m_y[s] + m_speed >= 480) begin
          m_act[s] = 0; m_exits++;
          if (m_missed < 255) m_missed++;
        end else begin
          m_y[s] += m_speed;
        end
      end
    end
    if (m_cnt != 0) begin
      m_cnt--;
    end else begin
      m_cnt = m_gap - 1;
      f = -1;
      for (int s = m_slots - 1; s >= 0; s--) if (!m_act[s]) f = s;
      if (f >= 0) begin
        m_act[f] = 1; m_y[f] = 0;
        m_lane[f] = (m_lfsr % 4 == 3) ? 0 : int'(m_lfsr % 4);
      end
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  function automatic bit model_vis(input int h, input int v);
    if (h >= 640 || v >= 480) return 0;
    for (int s = 0; s < m_slots; s++)
      if (m_act[s] && v >= m_y[s] && v < m_y[s] + NH && h >= lx0[m_lane[s]] && h < lx1[m_lane[s]])
        return 1;
    return 0;
  endfunction

  function automatic logic [2:0] model_liw();
    logic [2:0] r;
    r = 3'b000;
    for (int s = 0; s < m_slots; s++)
      if (m_act[s] && m_y[s] <= 383 && m_y[s] + NH > 380) r[m_lane[s]] = 1'b1;
    return r;
  endfunction

  task automatic run_frame();
    @(negedge clk); tb_h = 10'd0; tb_v = 10'd480;
    @(negedge clk); tb_h = 10'd1;
    repeat (m_slots + 2) @(negedge clk);
    tb_v = 10'd0;
  endtask

  task automatic probe(input int h, input int v);
    @(negedge clk);
    if (h == 0 && v == 480) h = 1;
    tb_h = 10'(h); tb_v = 10'(v);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk); tb_h = 10'd5; tb_v = 10'd0; tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_start = 1'b0; tb_h = 10'd5; tb_v = 10'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      probe(300, 2);
      vectors++; if (o_run !== 1'b0) begin miscompares++; $display("FAIL reset_running dut%0d: got %b want 0", d, o_run); end
      vectors++; if (o_miss !== 8'd0) begin miscompares++; $display("FAIL reset_missed dut%0d: got %0d want 0", d, o_miss); end
      vectors++; if (o_liw !== 3'd0) begin miscompares++; $display("FAIL reset_liw dut%0d: got %b want 000", d, o_liw); end
      vectors++; if (o_vis !== 1'b0) begin miscompares++; $display("FAIL reset_vis dut%0d: got %b want 0", d, o_vis); end
    end
    @(negedge clk); rst = 1'b0;
    sel = 0;
  endtask

  task automatic test_first_spawn();
    sel = 0;
    model_start(8, 2, 30);
    pulse_start();
    vectors++; if (o_run !== 1'b1) begin miscompares++; $display("FAIL start_running: got %b want 1", o_run); end
    run_frame(); model_frame();
    probe(100, 0);
    vectors++; if (o_vis !== 1'b0) begin miscompares++; $display("FAIL first_vis_h100: got %b want 0", o_vis); end
    probe(300, 2);
    vectors++; if (o_vis !== 1'b1) begin miscompares++; $display("FAIL first_vis_h300: got %b want 1", o_vis); end
    vectors++; if (o_miss !== 8'd0) begin miscompares++; $display("FAIL first_missed: got %0d want 0", o_miss); end
  endtask

  task automatic test_fall_window();
    int y_first;
    for (int n = 1; n <= 245; n++) begin
      run_frame(); model_frame();
      y_first = 2 * n;
      #1;
      vectors++; if (o_miss !== 8'(m_missed)) begin miscompares++; $display("FAIL fall_missed n=%0d: got %0d want %0d", n, o_miss, m_missed); end
      vectors++; if (o_liw !== model_liw()) begin miscompares++; $display("FAIL fall_liw n=%0d: got %b want %b", n, o_liw, model_liw()); end
      if (y_first == 364 || y_first == 384) begin
        vectors++; if (o_liw[1] !== 1'b0) begin miscompares++; $display("FAIL window_edge y=%0d: got %b want 0", y_first, o_liw[1]); end
      end
      if (y_first == 366 || y_first == 382) begin
        vectors++; if (o_liw[1] !== 1'b1) begin miscompares++; $display("FAIL window_edge y=%0d: got %b want 1", y_first, o_liw[1]); end
      end
      if (n == 240) begin
        vectors++; if (o_miss !== 8'd1) begin miscompares++; $display("FAIL first_exit_missed: got %0d want 1", o_miss); end
      end
      for (int s = 0; s < m_slots; s++) begin
        if (m_act[s]) begin
          int cx;
          cx = (lx0[m_lane[s]] + lx1[m_lane[s]]) / 2;
          probe(cx, m_y[s]);
          vectors++; if (o_vis !== model_vis(cx, m_y[s])) begin miscompares++; $display("FAIL fall_top s=%0d y=%0d: got %b want %b", s, m_y[s], o_vis, model_vis(cx, m_y[s])); end
          probe(cx, m_y[s] + NH);
          vectors++; if (o_vis !== model_vis(cx, m_y[s] + NH)) begin miscompares++; $display("FAIL fall_bot s=%0d y=%0d: got %b want %b", s, m_y[s], o_vis, model_vis(cx, m_y[s] + NH)); end
        end
      end
      for (int r = 0; r < 2; r++) begin
        int h, v;
        h = $urandom_range(799, 0); v = $urandom_range(524, 0);
        probe(h, v);
        vectors++; if (o_vis !== model_vis(h, v)) begin miscompares++; $display("FAIL fall_rand h=%0d v=%0d: got %b want %b", h, v, o_vis, model_vis(h, v)); end
      end
    end
  endtask

  task automatic test_reset_mid_update();
    sel = 0;
    @(negedge clk); tb_h = 10'd0; tb_v = 10'd480;
    @(posedge clk); #1 tb_h = 10'd1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (o_run !== 1'b0) begin miscompares++; $display("FAIL midrst_running: got %b want 0", o_run); end
    vectors++; if (o_miss !== 8'd0) begin miscompares++; $display("FAIL midrst_missed: got %0d want 0", o_miss); end
    vectors++; if (o_liw !== 3'd0) begin miscompares++; $display("FAIL midrst_liw: got %b want 000", o_liw); end
    tb_h = 10'd108; tb_v = 10'd20; #1;
    vectors++; if (o_vis !== 1'b0) begin miscompares++; $display("FAIL midrst_vis: got %b want 0", o_vis); end
    @(negedge clk); rst = 1'b0;
    model_start(8, 2, 30);
    repeat (2) run_frame();
    probe(300, 2);
    vectors++; if (o_run !== 1'b0) begin miscompares++; $display("FAIL idle_running: got %b want 0", o_run); end
    vectors++; if (o_vis !== 1'b0) begin miscompares++; $display("FAIL idle_vis: got %b want 0", o_vis); end
    pulse_start();
    run_frame(); model_frame();
    probe(300, 2);
    vectors++; if (o_run !== 1'b1) begin miscompares++; $display("FAIL restart_running: got %b want 1", o_run); end
    vectors++; if (o_vis !== 1'b1) begin miscompares++; $display("FAIL restart_vis: got %b want 1", o_vis); end
  endtask

  task automatic test_drop_and_sweep();
    int hs [9] = '{443, 444, 445, 500, 619, 620, 639, 640, 700};
    int vs [4] = '{99, 100, 115, 116};
    int pv [8] = '{2, 1, 17, 18, 1, 0, 16, 17};
    int ph [8] = '{300, 300, 300, 300, 500, 500, 500, 500};
    bit pe [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    sel = 1;
    model_start(2, 1, 1);
    pulse_start();
    repeat (3) begin run_frame(); model_frame(); end
    #1;
    vectors++; if (o_miss !== 8'd0) begin miscompares++; $display("FAIL drop_missed: got %0d want 0", o_miss); end
    for (int i = 0; i < 8; i++) begin
      probe(ph[i], pv[i]);
      vectors++; if (o_vis !== pe[i]) begin miscompares++; $display("FAIL drop_pos h=%0d v=%0d: got %b want %b", ph[i], pv[i], o_vis, pe[i]); end
    end
    for (int n = 3; n <= 101; n++) begin
      int h, v;
      run_frame(); model_frame();
      #1;
      vectors++; if (o_miss !== 8'(m_missed)) begin miscompares++; $display("FAIL b_missed n=%0d: got %0d want %0d", n, o_miss, m_missed); end
      h = $urandom_range(799, 0); v = $urandom_range(140, 0);
      probe(h, v);
      vectors++; if (o_vis !== model_vis(h, v)) begin miscompares++; $display("FAIL b_rand h=%0d v=%0d: got %b want %b", h, v, o_vis, model_vis(h, v)); end
    end
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 4; j++) begin
        bit want;
        want = (hs[i] >= 444 && hs[i] < 620 && vs[j] >= 100 && vs[j] < 116);
        probe(hs[i], vs[j]);
        vectors++; if (o_vis !== want) begin miscompares++; $display("FAIL sweep h=%0d v=%0d: got %b want %b", hs[i], vs[j], o_vis, want); end
      end
    end
  endtask

  task automatic test_saturation();
    int frames;
    sel = 2;
    model_start(16, 15, 1);
    pulse_start();
    frames = 0;
    while (m_exits < 262 && frames < 1200) begin
      int h, v;
      run_frame(); model_frame(); frames++;
      #1;
      vectors++; if (o_miss !== 8'(m_missed)) begin miscompares++; $display("FAIL sat_missed f=%0d: got %0d want %0d", frames, o_miss, m_missed); end
      vectors++; if (o_liw !== model_liw()) begin miscompares++; $display("FAIL sat_liw f=%0d: got %b want %b", frames, o_liw, model_liw()); end
      h = $urandom_range(799, 0); v = $urandom_range(524, 0);
      probe(h, v);
      vectors++; if (o_vis !== model_vis(h, v)) begin miscompares++; $display("FAIL sat_rand h=%0d v=%0d: got %b want %b", h, v, o_vis, model_vis(h, v)); end
    end
    vectors++; if (m_exits < 262) begin miscompares++; $display("FAIL sat_bound: exits %0d want >=262 within 1200 frames", m_exits); end
    vectors++; if (o_miss !== 8'd255) begin miscompares++; $display("FAIL sat_final: got %0d want 255", o_miss); end
  endtask

  initial begin
    vectors = 0; miscompares = 0; sel = 0;
    m_slots = 8;
    test_reset();
    test_first_spawn();
    test_fall_window();
    test_reset_mid_update();
    test_drop_and_sweep();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
